// File: rtl/draw_pkg.sv
// Shared constants and FSM encoding for the drawing-engine VIF write path.
package draw_pkg;
    localparam int VIF_DW     = 64;
    localparam int VIF_LEN_W  = 8;
    localparam int BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;
endpackage

// File: rtl/draw_wfifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty, word count and clear.
module draw_wfifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push, pop;

    assign push = wr & ~full_q;
    assign pop  = rd & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage has no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = cnt_q;
endmodule

// File: rtl/draw_dstbuf.sv
// Destination buffer: queues pixel words and drains them to VRAM as VIF burst writes.
module draw_dstbuf
    import draw_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 32,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 INIT,
    input  logic                 START,
    input  logic [ADDR_W-1:0]    DST_ADDR,
    input  logic [VIF_DW-1:0]    PIX_WDATA,
    input  logic                 PIX_WR,
    input  logic                 FLUSH,
    output logic                 VIF_DRWREQ,
    output logic [ADDR_W-1:0]    VIF_DRWADDR,
    output logic [VIF_LEN_W-1:0] VIF_DRWLEN,
    input  logic                 VIF_DRWACK,
    output logic [VIF_DW-1:0]    VIF_WDATA,
    output logic                 VIF_DRWWDATAVLD,
    input  logic                 VIF_WRDY,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic                 BUF_OVER,
    output logic                 BUSY,
    output logic [CW-1:0]        DATA_COUNT
);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [VIF_LEN_W-1:0]   len_q, len_d;
    logic [VIF_LEN_W-1:0]   beats_q, beats_d;
    logic                   req_q, req_d;
    logic                   vld_q, vld_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   over_q, over_d;

    logic [VIF_DW-1:0]      fifo_rdata;
    logic                   fifo_full, fifo_empty, fifo_rd;
    logic [CW-1:0]          fifo_count;

    assign fifo_rd = vld_q & VIF_WRDY;

    draw_wfifo #(.W(VIF_DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .clr   (INIT),
        .wr    (PIX_WR),
        .wdata (PIX_WDATA),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beats_d      = beats_q;
        req_d        = req_q;
        vld_d        = vld_q;
        flush_pend_d = flush_pend_q;
        over_d       = PIX_WR & fifo_full & ~INIT;

        if (INIT) begin
            state_d      = ST_IDLE;
            req_d        = 1'b0;
            vld_d        = 1'b0;
            beats_d      = '0;
            flush_pend_d = 1'b0;
        end else begin
            if (FLUSH)
                flush_pend_d = 1'b1;
            else if (state_q == ST_IDLE && fifo_empty)
                flush_pend_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (START) addr_d = DST_ADDR;
                    // A full burst is always preferred over draining a partial one.
                    if (fifo_count >= BURST_CNT) begin
                        len_d   = VIF_LEN_W'(BURST_LEN);
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end else if (flush_pend_q && !fifo_empty) begin
                        len_d   = VIF_LEN_W'(fifo_count);
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (VIF_DRWACK) begin
                        state_d = ST_DATA;
                        req_d   = 1'b0;
                        vld_d   = 1'b1;
                        beats_d = len_q;
                    end
                end
                ST_DATA: begin
                    if (fifo_rd) begin
                        beats_d = beats_q - 1'b1;
                        if (beats_q == VIF_LEN_W'(1)) begin
                            vld_d   = 1'b0;
                            state_d = ST_IDLE;
                            addr_d  = addr_q + ADDR_W'(len_q) * ADDR_W'(BEAT_BYTES);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beats_q      <= '0;
            req_q        <= 1'b0;
            vld_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beats_q      <= beats_d;
            req_q        <= req_d;
            vld_q        <= vld_d;
            flush_pend_q <= flush_pend_d;
            over_q       <= over_d;
        end
    end

    assign VIF_DRWREQ      = req_q;
    assign VIF_DRWADDR     = addr_q;
    assign VIF_DRWLEN      = len_q;
    assign VIF_DRWWDATAVLD = vld_q;
    assign VIF_WDATA       = vld_q ? fifo_rdata : '0;
    assign EMPTY           = fifo_empty;
    assign FULL            = fifo_full;
    assign BUF_OVER        = over_q;
    assign BUSY            = (state_q != ST_IDLE) | flush_pend_q;
    assign DATA_COUNT      = fifo_count;
endmodule

// File: tb/tb_draw_dstbuf.sv
// Self-checking bench for draw_dstbuf: table of bursts plus overflow and INIT sequences.
module tb_draw_dstbuf;
    logic        CLK;
    logic        RST;
    logic        INIT;
    logic        START;
    logic [31:0] DST_ADDR;
    logic [63:0] PIX_WDATA;
    logic        PIX_WR;
    logic        FLUSH;
    logic        VIF_DRWREQ;
    logic [31:0] VIF_DRWADDR;
    logic [7:0]  VIF_DRWLEN;
    logic        VIF_DRWACK;
    logic [63:0] VIF_WDATA;
    logic        VIF_DRWWDATAVLD;
    logic        VIF_WRDY;
    logic        EMPTY;
    logic        FULL;
    logic        BUF_OVER;
    logic        BUSY;
    logic [4:0]  DATA_COUNT;

    draw_dstbuf #(.DEPTH(16), .BURST_LEN(8), .ADDR_W(32)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .INIT            (INIT),
        .START           (START),
        .DST_ADDR        (DST_ADDR),
        .PIX_WDATA       (PIX_WDATA),
        .PIX_WR          (PIX_WR),
        .FLUSH           (FLUSH),
        .VIF_DRWREQ      (VIF_DRWREQ),
        .VIF_DRWADDR     (VIF_DRWADDR),
        .VIF_DRWLEN      (VIF_DRWLEN),
        .VIF_DRWACK      (VIF_DRWACK),
        .VIF_WDATA       (VIF_WDATA),
        .VIF_DRWWDATAVLD (VIF_DRWWDATAVLD),
        .VIF_WRDY        (VIF_WRDY),
        .EMPTY           (EMPTY),
        .FULL            (FULL),
        .BUF_OVER        (BUF_OVER),
        .BUSY            (BUSY),
        .DATA_COUNT      (DATA_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        start;
        logic [31:0] dst;
        int          nwords;
        logic        flush;
        int          ack_dly;
        logic        toggle;
        logic [7:0]  exp_len;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] exp_q [$];
    logic [63:0] word_ctr;
    int          checks;
    int          errors;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            PIX_WR    = 1'b1;
            PIX_WDATA = word_ctr;
            exp_q.push_back(word_ctr);
            word_ctr  = word_ctr + 64'd1;
            tick();
        end
        PIX_WR = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] elen, input logic [31:0] eaddr,
                             input int ack_dly, input logic toggle);
        bit ok;
        int got;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (VIF_DRWREQ) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("req_seen", 64'(ok), 64'd1);
        if (!ok) return;
        chk("req_addr", 64'(VIF_DRWADDR), 64'(eaddr));
        chk("req_len", 64'(VIF_DRWLEN), 64'(elen));
        for (int d = 0; d < ack_dly; d++) begin
            tick();
            chk("req_hold", 64'(VIF_DRWREQ), 64'd1);
            chk("addr_hold", 64'(VIF_DRWADDR), 64'(eaddr));
        end
        VIF_DRWACK = 1'b1;
        tick();
        VIF_DRWACK = 1'b0;
        chk("req_drop", 64'(VIF_DRWREQ), 64'd0);
        got = 0;
        for (int c = 0; c < 200 && got < int'(elen); c++) begin
            VIF_WRDY = toggle ? (c % 2 == 0) : 1'b1;
            if (VIF_DRWWDATAVLD) begin
                if (exp_q.size() == 0) begin
                    chk("beat_extra", 64'(VIF_DRWWDATAVLD), 64'd0);
                end else begin
                    chk("beat_data", VIF_WDATA, exp_q[0]);
                    if (VIF_WRDY) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            tick();
        end
        VIF_WRDY = 1'b1;
        chk("beat_count", 64'(got), 64'(elen));
        chk("vld_drop", 64'(VIF_DRWWDATAVLD), 64'd0);
        $display("burst addr=%h len=%0d beats=%0d", eaddr, elen, got);
    endtask

    task automatic idle_chk();
        tick();
        tick();
        chk("idle_empty", 64'(EMPTY), 64'd1);
        chk("idle_busy", 64'(BUSY), 64'd0);
        chk("idle_count", 64'(DATA_COUNT), 64'd0);
        chk("idle_full", 64'(FULL), 64'd0);
    endtask

    initial begin
        bit ok;
        checks     = 0;
        errors     = 0;
        word_ctr   = 64'd1;
        RST        = 1'b1;
        INIT       = 1'b0;
        START      = 1'b0;
        DST_ADDR   = '0;
        PIX_WDATA  = '0;
        PIX_WR     = 1'b0;
        FLUSH      = 1'b0;
        VIF_DRWACK = 1'b0;
        VIF_WRDY   = 1'b1;

        //         start  dst           n  flush ack tog  len   addr
        vecs[0] = '{1'b1, 32'h0000_1000, 8, 1'b0, 3, 1'b0, 8'd8, 32'h0000_1000};
        vecs[1] = '{1'b0, 32'h0,         3, 1'b1, 0, 1'b0, 8'd3, 32'h0000_1040};
        vecs[2] = '{1'b0, 32'h0,         8, 1'b0, 1, 1'b1, 8'd8, 32'h0000_1058};
        vecs[3] = '{1'b1, 32'hFFFF_FFC0, 8, 1'b0, 2, 1'b0, 8'd8, 32'hFFFF_FFC0};
        vecs[4] = '{1'b0, 32'h0,         5, 1'b1, 0, 1'b1, 8'd5, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0,         1, 1'b1, 0, 1'b0, 8'd1, 32'h0000_0028};

        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("rst_req", 64'(VIF_DRWREQ), 64'd0);
        chk("rst_vld", 64'(VIF_DRWWDATAVLD), 64'd0);
        chk("rst_addr", 64'(VIF_DRWADDR), 64'd0);
        chk("rst_len", 64'(VIF_DRWLEN), 64'd0);
        chk("rst_wdata", VIF_WDATA, 64'd0);
        chk("rst_empty", 64'(EMPTY), 64'd1);
        chk("rst_full", 64'(FULL), 64'd0);
        chk("rst_over", 64'(BUF_OVER), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_count", 64'(DATA_COUNT), 64'd0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].start) begin
                START    = 1'b1;
                DST_ADDR = vecs[v].dst;
                tick();
                START    = 1'b0;
            end
            push_words(vecs[v].nwords);
            if (vecs[v].flush) begin
                FLUSH = 1'b1;
                tick();
                FLUSH = 1'b0;
            end
            run_burst(vecs[v].exp_len, vecs[v].exp_addr, vecs[v].ack_dly, vecs[v].toggle);
            idle_chk();
        end

        // Overflow: 16 words, ACK held low, two extra pushes must be dropped.
        push_words(16);
        chk("ovf_full", 64'(FULL), 64'd1);
        chk("ovf_count16", 64'(DATA_COUNT), 64'd16);
        PIX_WR    = 1'b1;
        PIX_WDATA = 64'hDEAD_0001;
        tick();
        chk("ovf_pulse1", 64'(BUF_OVER), 64'd1);
        PIX_WDATA = 64'hDEAD_0002;
        tick();
        chk("ovf_pulse2", 64'(BUF_OVER), 64'd1);
        PIX_WR = 1'b0;
        tick();
        chk("ovf_pulse_end", 64'(BUF_OVER), 64'd0);
        chk("ovf_count_kept", 64'(DATA_COUNT), 64'd16);
        run_burst(8'd8, 32'h0000_0030, 0, 1'b0);
        run_burst(8'd8, 32'h0000_0070, 0, 1'b0);
        idle_chk();

        // INIT during the 4th beat abandons the burst and keeps the address.
        push_words(8);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (VIF_DRWREQ) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("init_req_seen", 64'(ok), 64'd1);
        chk("init_req_addr", 64'(VIF_DRWADDR), 64'h0000_00B0);
        VIF_DRWACK = 1'b1;
        tick();
        VIF_DRWACK = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk("init_beat_data", VIF_WDATA, exp_q.size() > 0 ? exp_q[0] : 64'hX);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            tick();
        end
        chk("init_vld_beat4", 64'(VIF_DRWWDATAVLD), 64'd1);
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        exp_q.delete();
        chk("init_req", 64'(VIF_DRWREQ), 64'd0);
        chk("init_vld", 64'(VIF_DRWWDATAVLD), 64'd0);
        chk("init_empty", 64'(EMPTY), 64'd1);
        chk("init_count", 64'(DATA_COUNT), 64'd0);
        chk("init_busy", 64'(BUSY), 64'd0);
        chk("init_addr_kept", 64'(VIF_DRWADDR), 64'h0000_00B0);
        $display("init mid-burst addr=%h", VIF_DRWADDR);

        push_words(1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        run_burst(8'd1, 32'h0000_00B0, 0, 1'b0);
        idle_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
